// File: rtl/hft_sched_pkg.sv
// Shared types and constants for the hft_zero_plus core scheduler.
package hft_sched_pkg;

    // Market-data snapshot as presented by a feed requester; bid_price sits in the MSBs.
    typedef struct packed {
        logic [31:0] bid_price;
        logic [31:0] ask_price;
        logic [31:0] bid_qty;
        logic [31:0] ask_qty;
        logic        bid_strong;
        logic        ask_strong;
        logic [31:0] position;
    } md_snapshot_t;

    localparam int unsigned SNAP_W = 162;

    // Scheduler FSM encodings, kept as plain constants for the legacy state register.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_ISSUE = ST_ISSUE,
        S_WAIT  = ST_WAIT,
        S_RESP  = ST_RESP
    } sched_state_t;

    // Decision action returned when the watchdog abandons a job.
    localparam logic [1:0] ACT_HOLD = 2'd0;

    // Saturating 16-bit increment used for the abandoned-job counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/hft_rr_arbiter.sv
// Round-robin pick among snapshot requesters, with the rotating priority pointer.
module hft_rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_REQ-1:0] req_valid,
    output logic [N_REQ-1:0] grant_vec,
    output logic [ID_W-1:0]  grant_id,
    output logic             grant_any
);

    logic [ID_W-1:0] rr_ptr;
    logic            found;
    logic [ID_W-1:0] pick;

    // First valid requester at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!found && req_valid[(32'(rr_ptr) + i) % N_REQ]) begin
                found = 1'b1;
                pick  = ID_W'((32'(rr_ptr) + i) % N_REQ);
            end
        end
    end

    // Grant only when the scheduler can accept; one-hot decode of the pick.
    always_comb begin
        grant_any = en && found;
        grant_id  = pick;
        grant_vec = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            grant_vec[i] = grant_any && (pick == ID_W'(i));
        end
    end

    // Pointer moves to the requester after the winner on every grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (grant_any) begin
            rr_ptr <= (pick == ID_W'(N_REQ - 1)) ? '0 : pick + ID_W'(1);
        end
    end

endmodule

// File: rtl/hft_core_scheduler.sv
// Shares one hft_zero_plus decision core among N_REQ snapshot feeds:
// round-robin accept, ap_start/ap_done sequencing with a watchdog, and a
// tagged valid/ready response channel.
module hft_core_scheduler
    import hft_sched_pkg::*;
#(
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned ID_W           = $clog2(N_REQ)
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*SNAP_W-1:0] req_snap,
    output logic                    core_start,
    input  logic                    core_done,
    input  logic                    core_idle,
    output logic [SNAP_W-1:0]       core_snap,
    input  logic [1:0]              core_action,
    input  logic [31:0]             core_price,
    input  logic [31:0]             core_qty,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [1:0]              rsp_action,
    output logic [31:0]             rsp_price,
    output logic [31:0]             rsp_qty,
    output logic                    rsp_timeout,
    output logic                    busy,
    output logic [15:0]             timeout_count
);

    localparam int unsigned     TMR_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [TMR_W-1:0]  timer_q;
    logic              grant_en;
    logic              grant_any;
    logic [ID_W-1:0]   grant_id;
    logic [N_REQ-1:0]  grant_vec;
    logic [SNAP_W-1:0] grant_snap;
    logic              done_hit;
    logic              expire;

    // Accept only from IDLE with the core idle; held off while reset is asserted
    // so a requester never sees an accept that the registers then discard.
    assign grant_en  = (state_q == ST_IDLE) && core_idle && !ap_rst;
    assign req_ready = grant_vec;

    hft_rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .clk       (ap_clk),
        .rst       (ap_rst),
        .en        (grant_en),
        .req_valid (req_valid),
        .grant_vec (grant_vec),
        .grant_id  (grant_id),
        .grant_any (grant_any)
    );

    // Select the winning requester's snapshot.
    always_comb begin
        grant_snap = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                grant_snap = req_snap[i*SNAP_W +: SNAP_W];
            end
        end
    end

    // Done beats the watchdog when both land in the same WAIT cycle.
    always_comb begin
        done_hit = (state_q == ST_WAIT) && core_done;
        expire   = (state_q == ST_WAIT) && !core_done && (timer_q == TMR_LAST);
    end

    // Next-state logic for IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (grant_any) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (done_hit || expire) state_d = ST_RESP;
            ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State register plus registered start pulse (high only in ISSUE) and busy flag.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q    <= ST_IDLE;
            core_start <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            core_start <= grant_any;
            busy       <= (state_d != ST_IDLE);
        end
    end

    // Watchdog: cleared while issuing, counts WAIT cycles without done.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            timer_q <= '0;
        end else if (state_q == ST_ISSUE) begin
            timer_q <= '0;
        end else if ((state_q == ST_WAIT) && !core_done && !expire) begin
            timer_q <= timer_q + TMR_W'(1);
        end
    end

    // Latch the accepted snapshot and its requester tag at grant.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            core_snap <= '0;
            rsp_id    <= '0;
        end else if (grant_any) begin
            core_snap <= grant_snap;
            rsp_id    <= grant_id;
        end
    end

    // Response registers: filled on done or expiry, held until the handshake.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            rsp_valid     <= 1'b0;
            rsp_action    <= '0;
            rsp_price     <= '0;
            rsp_qty       <= '0;
            rsp_timeout   <= 1'b0;
            timeout_count <= '0;
        end else if (done_hit) begin
            rsp_valid   <= 1'b1;
            rsp_action  <= core_action;
            rsp_price   <= core_price;
            rsp_qty     <= core_qty;
            rsp_timeout <= 1'b0;
        end else if (expire) begin
            rsp_valid     <= 1'b1;
            rsp_action    <= ACT_HOLD;
            rsp_price     <= '0;
            rsp_qty       <= '0;
            rsp_timeout   <= 1'b1;
            timeout_count <= sat_inc16(timeout_count);
        end else if ((state_q == ST_RESP) && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hft_core_scheduler.sv
// Directed bench for hft_core_scheduler (N_REQ=4, TIMEOUT_CYCLES=8).
// Inputs are driven and outputs sampled on the falling edge.
module tb_hft_core_scheduler;
    import hft_sched_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned TO = 8;

    logic                ap_clk = 1'b0;
    logic                ap_rst;
    logic [N-1:0]        req_valid;
    logic [N-1:0]        req_ready;
    logic [N*SNAP_W-1:0] req_snap;
    logic                core_start;
    logic                core_done;
    logic                core_idle;
    logic [SNAP_W-1:0]   core_snap;
    logic [1:0]          core_action;
    logic [31:0]         core_price;
    logic [31:0]         core_qty;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [1:0]          rsp_id;
    logic [1:0]          rsp_action;
    logic [31:0]         rsp_price;
    logic [31:0]         rsp_qty;
    logic                rsp_timeout;
    logic                busy;
    logic [15:0]         timeout_count;

    md_snapshot_t snaps [N];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 ap_clk = ~ap_clk;

    hft_core_scheduler #(
        .N_REQ          (N),
        .TIMEOUT_CYCLES (TO),
        .ID_W           (2)
    ) dut (
        .ap_clk        (ap_clk),
        .ap_rst        (ap_rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_snap      (req_snap),
        .core_start    (core_start),
        .core_done     (core_done),
        .core_idle     (core_idle),
        .core_snap     (core_snap),
        .core_action   (core_action),
        .core_price    (core_price),
        .core_qty      (core_qty),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_action    (rsp_action),
        .rsp_price     (rsp_price),
        .rsp_qty       (rsp_qty),
        .rsp_timeout   (rsp_timeout),
        .busy          (busy),
        .timeout_count (timeout_count)
    );

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge ap_clk);
    endtask

    function automatic md_snapshot_t mk_snap(input logic [31:0] bid, input logic [31:0] ask);
        md_snapshot_t s;
        s.bid_price  = bid;
        s.ask_price  = ask;
        s.bid_qty    = 32'd10;
        s.ask_qty    = 32'd12;
        s.bid_strong = 1'b1;
        s.ask_strong = 1'b0;
        s.position   = 32'd3;
        return s;
    endfunction

    task automatic set_snap(input int unsigned i, input md_snapshot_t s);
        snaps[i] = s;
        req_snap[i*SNAP_W +: SNAP_W] = s;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_core_start"}, core_start, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_timeout"}, rsp_timeout, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_timeout_count"}, timeout_count, 0);
        check({tag, "_core_snap"}, core_snap, 0);
        check({tag, "_rsp_id"}, rsp_id, 0);
        check({tag, "_rsp_action"}, rsp_action, 0);
        check({tag, "_rsp_price"}, rsp_price, 0);
        check({tag, "_rsp_qty"}, rsp_qty, 0);
    endtask

    // Entered at the falling edge of an IDLE cycle; returns at the ISSUE cycle.
    task automatic grant_issue(input string tag, input logic [3:0] mask, input int unsigned g);
        logic [3:0] oh;
        oh = 4'b0001 << g;
        req_valid = mask;
        #1;
        check({tag, "_req_ready"}, req_ready, oh);
        cyc();
        req_valid[g] = 1'b0;
        check({tag, "_core_start"}, core_start, 1);
        check({tag, "_core_snap"}, core_snap, snaps[g]);
        check({tag, "_busy"}, busy, 1);
    endtask

    // Done asserted in the k-th WAIT cycle; returns at the RESP cycle.
    task automatic finish_job(input string tag, input int unsigned g, input int unsigned k,
                              input logic [1:0] act, input logic [31:0] price, input logic [31:0] qty);
        for (int unsigned c = 1; c <= k; c++) begin
            cyc();
            if (c == 1) check({tag, "_start_pulse"}, core_start, 0);
            if (c == k) begin
                core_done   = 1'b1;
                core_action = act;
                core_price  = price;
                core_qty    = qty;
            end
        end
        cyc();
        core_done = 1'b0;
        check({tag, "_rsp_valid"}, rsp_valid, 1);
        check({tag, "_rsp_id"}, rsp_id, g);
        check({tag, "_rsp_action"}, rsp_action, act);
        check({tag, "_rsp_price"}, rsp_price, price);
        check({tag, "_rsp_qty"}, rsp_qty, qty);
        check({tag, "_rsp_timeout"}, rsp_timeout, 0);
    endtask

    task automatic run_job(input string tag, input logic [3:0] mask, input int unsigned g, input int unsigned k,
                           input logic [1:0] act, input logic [31:0] price, input logic [31:0] qty);
        grant_issue(tag, mask, g);
        finish_job(tag, g, k, act, price, qty);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        ap_rst      = 1'b1;
        req_valid   = '0;
        req_snap    = '0;
        core_done   = 1'b0;
        core_idle   = 1'b1;
        core_action = '0;
        core_price  = '0;
        core_qty    = '0;
        rsp_ready   = 1'b1;
        for (int unsigned i = 0; i < N; i++) set_snap(i, mk_snap(32'd1000 + i, 32'd2000 + i));

        cyc();
        cyc();
        check_reset("reset");
        ap_rst = 1'b0;
        cyc();

        // Round-robin with all requesters pending, back-to-back 4-cycle jobs: 0,1,2,3,0.
        for (int unsigned j = 0; j < 5; j++) begin
            run_job("rr", 4'b1111, j % 4, 1, 2'(j % 3), 32'd200 + j, 32'd10 + j);
            cyc();
        end

        // Single request from requester 0 (pointer at 1 wraps round to 0).
        set_snap(0, mk_snap(32'd100, 32'd101));
        run_job("single", 4'b0001, 0, 3, 2'd1, 32'd100, 32'd5);
        cyc();
        check("single_rsp_drop", rsp_valid, 0);
        check("single_idle", busy, 0);

        // Backpressure: response held for 20 cycles while requester 2 waits.
        rsp_ready = 1'b0;
        run_job("bp", 4'b0010, 1, 1, 2'd2, 32'd333, 32'd44);
        req_valid = 4'b0100;
        for (int unsigned i = 0; i < 20; i++) begin
            cyc();
            check("bp_valid", rsp_valid, 1);
            check("bp_id", rsp_id, 1);
            check("bp_action", rsp_action, 2);
            check("bp_price", rsp_price, 333);
            check("bp_qty", rsp_qty, 44);
            check("bp_no_grant", req_ready, 0);
            check("bp_no_start", core_start, 0);
        end
        rsp_ready = 1'b1;
        check("bp_release_valid", rsp_valid, 1);
        cyc();
        check("bp_after_valid", rsp_valid, 0);
        check("bp_after_busy", busy, 0);
        run_job("bp_next", 4'b0100, 2, 2, 2'd1, 32'd555, 32'd6);
        cyc();

        // Done in exactly the expiry cycle; pointer at 3 wraps to 0.
        run_job("tie", 4'b0001, 0, TO, 2'd2, 32'd77, 32'd9);
        check("tie_timeout_count", timeout_count, 0);
        cyc();

        // Watchdog expiry: no done, response at T+10.
        grant_issue("to", 4'b0100, 2);
        core_action = 2'd3;
        core_price  = 32'hDEAD;
        core_qty    = 32'h55;
        for (int unsigned c = 1; c <= TO; c++) cyc();
        check("to_early", rsp_valid, 0);
        cyc();
        check("to_rsp_valid", rsp_valid, 1);
        check("to_rsp_timeout", rsp_timeout, 1);
        check("to_rsp_id", rsp_id, 2);
        check("to_rsp_action", rsp_action, 0);
        check("to_rsp_price", rsp_price, 0);
        check("to_rsp_qty", rsp_qty, 0);
        check("to_count", timeout_count, 1);
        cyc();

        // Core still busy after the timeout: no grant while core_idle is low.
        core_idle = 1'b0;
        req_valid = 4'b0110;
        for (int unsigned i = 0; i < 5; i++) begin
            #1;
            check("noidle_ready", req_ready, 0);
            check("noidle_busy", busy, 0);
            cyc();
        end
        core_idle = 1'b1;

        // Reset during WAIT discards the job and restarts the pointer at 0.
        grant_issue("rst", 4'b0110, 1);
        cyc();
        cyc();
        ap_rst = 1'b1;
        cyc();
        check_reset("rst_mid");
        ap_rst = 1'b0;
        run_job("post_rst", 4'b1111, 0, 1, 2'd1, 32'd42, 32'd7);
        cyc();
        check("post_rst_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hft_core_scheduler.md
# hft_core_scheduler

Sequencing and sharing controller for one `hft_zero_plus` decision core. It accepts market-data snapshots from `N_REQ` feed requesters over valid/ready and arbitrates between them round-robin. It drives the core's `ap_start`/`ap_done` handshake, guards it with a watchdog timeout, and returns the tagged decision on a valid/ready response channel. It replaces direct per-snapshot driving of the core by a single feed.

## Interface
Parameters:
- `N_REQ`, 4: number of snapshot requesters, 2..8.
- `TIMEOUT_CYCLES`, 64: WAIT cycles before a job is abandoned; must be ≥2.
- `ID_W`, `$clog2(N_REQ)`: requester tag width.

Ports:
- `ap_clk`, in, 1: the single clock.
- `ap_rst`, in, 1: synchronous, active-high reset.
- `req_valid`, in, N_REQ: per-requester snapshot valid.
- `req_ready`, out, N_REQ: one-hot accept pulse.
- `req_snap`, in, N_REQ×SNAP_W: packed `md_snapshot_t` per requester.
- `core_start`, out, 1: to core `ap_start`.
- `core_done`, in, 1: core `ap_done`.
- `core_idle`, in, 1: core `ap_idle`.
- `core_snap`, out, SNAP_W: registered snapshot fanned out to the core inputs.
- `core_action`, in, 2: core decision.
- `core_price`, in, 32: core decision price.
- `core_qty`, in, 32: core decision quantity.
- `rsp_valid`, out, 1: response valid.
- `rsp_ready`, in, 1: response ready.
- `rsp_id`, out, ID_W: requester index of the response.
- `rsp_action`, out, 2: decision action.
- `rsp_price`, out, 32: decision price.
- `rsp_qty`, out, 32: decision quantity.
- `rsp_timeout`, out, 1: set when the response was produced by the watchdog.
- `busy`, out, 1: high when the FSM is not in IDLE.
- `timeout_count`, out, 16: saturating count of abandoned jobs.

## Operation
FSM states: IDLE, ISSUE, WAIT, RESP.

- **IDLE:** a grant occurs when any `req_valid` is high **and** `core_idle`=1.
  - Winner g is the first set bit at or after `rr_ptr`, wrapping modulo N_REQ.
  - `req_ready[g]`=1 for that single cycle.
  - `req_snap[g]` is latched into `core_snap`, g into `rsp_id`.
  - Next state is ISSUE; `rr_ptr` becomes (g+1) mod N_REQ.
- **ISSUE:** `core_start`=1 for exactly this cycle; the watchdog timer is cleared; next state is WAIT. A `core_done` seen here is ignored.
- **WAIT:**
  - On `core_done`=1: capture `core_action`, `core_price` and `core_qty` into the rsp registers, set `rsp_timeout`=0, go to RESP.
  - Otherwise the timer increments. When it reaches TIMEOUT_CYCLES-1 with no done: set rsp action/price/qty to 0 (hold), `rsp_timeout`=1, `timeout_count`+=1 saturating at 0xFFFF, go to RESP.
  - If done and expiry occur in the same cycle, done wins.
- **RESP:** `rsp_valid`=1 and all rsp fields are held stable until `rsp_ready`=1; then go to IDLE. `rsp_valid` and `rsp_ready` may be high in the same cycle.
- **Requester rule:** a requester must hold `req_valid` and `req_snap` stable until accepted. The block never drops a presented request.
- **Late `core_done` after a timeout:** it is not consumed. The `core_idle` gating in IDLE prevents a new start until the core recovers.

## Timing
- **Reset:** `ap_rst`=1 at a clock edge returns the block to IDLE with `rr_ptr`=0.
  - `req_ready`, `core_start`, `rsp_valid`, `rsp_timeout`, `busy` and `timeout_count` are all 0.
  - `core_snap`, `rsp_id`, `rsp_action`, `rsp_price` and `rsp_qty` are all 0.
- **Reset mid-operation:** an in-flight job and any pending response are discarded without a handshake.
- **Accept to start:** accept in cycle T; `core_start` in T+1.
- **Done to response:** `core_done` in cycle T+1+k (k≥1) gives `rsp_valid` in T+2+k.
- **Timeout:** with no done, `rsp_valid` rises in T+2+TIMEOUT_CYCLES.
- **Back-to-back:** the minimum spacing is 4 cycles per job (IDLE, ISSUE, WAIT, RESP) with done at k=1 and `rsp_ready` held high.
- **Registered outputs:** all outputs are registered except `req_ready`, which is a combinational decode of the IDLE grant.

## Structure
- **Package `hft_sched_pkg`:**
  - `md_snapshot_t`, a packed struct: `bid_price`[32], `ask_price`[32], `bid_qty`[32], `ask_qty`[32], `bid_strong`[1], `ask_strong`[1], `position`[32].
  - `SNAP_W`=162.
  - `sched_state_t` enum.
  - `ACT_HOLD`=2'd0.
- **Sub-module `hft_rr_arbiter`:** combinational round-robin pick from `req_valid` and `rr_ptr`, plus the pointer register updated on grant.
- **Top level:** FSM, watchdog timer, snapshot and response registers.

## Test plan
- **Single request:** `req_valid`=0001 with bid 100, ask 101, core done at k=3 returning action 1, price 100, qty 5 → one `core_start` pulse; `rsp_valid` with id 0, action 1, price 100, qty 5, `rsp_timeout`=0.
- **Round-robin:** all four requesters held valid, core done at k=1 → grant order 0,1,2,3,0, each response carrying the matching id.
- **Timeout:** TIMEOUT_CYCLES=8, core never asserts done → response in T+10 with `rsp_timeout`=1, action/price/qty 0, `timeout_count`=1. With `core_idle`=0 afterward, no new grant occurs.
- **Backpressure:** `rsp_ready`=0 for 20 cycles → rsp fields are stable, no new grant, `req_ready` stays 0; the release cycle completes the handshake.
- **Simultaneous done and expiry:** done in exactly the expiry cycle → `rsp_timeout`=0 with the core values returned.
- **Reset mid-WAIT:** `ap_rst` asserted during WAIT → the next cycle shows all outputs at their reset values; the first subsequent grant goes to requester 0.
